// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: N-phase intersection light controller.
//   Each phase cycles GREEN -> YELLOW -> ALL_RED, and then the next non-skipped phase
//   is served. Green times are per phase. The yellow time is shared by all phases.
//   A flashing-yellow fail-safe mode is available.
// Ports:
//   clk, rst_n          clock and async active-low reset
//   en_i                enable; low forces IDLE (highest priority)
//   tick_i              1-cycle strobe per second, used as the timing base
//   green_time_i        per-phase green durations, phase p at [p*CNT_WIDTH +: CNT_WIDTH]
//   yellow_time_i       shared yellow duration
//   phase_skip_i        1 = do not serve phase p
//   flash_i             fail-safe flashing-yellow request
//   light_o             phase p at [p*3 +: 3]: bit0 green, bit1 yellow, bit2 red
//   active_phase_o      phase currently served
//   remaining_o         ticks left in the current interval, minus 1
//   phase_done_o        1-cycle pulse when ALL_RED expires

// Per-phase lamp decode, driven from next-state so the lamps register together with the state.
module traffic_phase_lamp (
  input  logic       idle_i,
  input  logic       flash_i,
  input  logic       blink_i,
  input  logic       green_i,
  input  logic       yellow_i,
  output logic [2:0] lamp_o
);
  always_comb begin
    lamp_o = 3'b100;
    if (idle_i)        lamp_o = 3'b000;
    else if (flash_i)  lamp_o = {1'b0, blink_i, 1'b0};
    else if (green_i)  lamp_o = 3'b001;
    else if (yellow_i) lamp_o = 3'b010;
  end
endmodule

module traffic_phase_ctrl #(
  parameter int NUM_PHASES   = 2,
  parameter int CNT_WIDTH    = 8,
  parameter int ALL_RED_TIME = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en_i,
  input  logic                            tick_i,
  input  logic [NUM_PHASES*CNT_WIDTH-1:0] green_time_i,
  input  logic [CNT_WIDTH-1:0]            yellow_time_i,
  input  logic [NUM_PHASES-1:0]           phase_skip_i,
  input  logic                            flash_i,
  output logic [NUM_PHASES*3-1:0]         light_o,
  output logic [((NUM_PHASES>1)?$clog2(NUM_PHASES):1)-1:0] active_phase_o,
  output logic [CNT_WIDTH-1:0]            remaining_o,
  output logic                            phase_done_o
);
  localparam int PH_W = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_GREEN, S_YELLOW, S_ALLRED, S_FLASH} state_e;

  state_e                          state_q, state_d;
  logic [PH_W-1:0]                 phase_q, phase_d;
  logic [CNT_WIDTH-1:0]            rem_q, rem_d;
  logic                            blink_q, blink_d;
  logic                            done_q, done_d;
  logic [NUM_PHASES-1:0][2:0]      light_q, light_d;
  logic [PH_W-1:0]                 nxt_ph;

  // A zero duration behaves as one tick.
  function automatic logic [CNT_WIDTH-1:0] load(input logic [CNT_WIDTH-1:0] d);
    return (d == '0) ? '0 : d - 1'b1;
  endfunction

  // First non-skipped phase after p with wrap-around. Falls back to p itself, then to p+1
  // when every phase is skipped, so the controller never stalls.
  function automatic logic [PH_W-1:0] next_phase(input logic [PH_W-1:0] p,
                                                 input logic [NUM_PHASES-1:0] skip);
    logic [PH_W-1:0] r;
    logic            found;
    int              c;
    found = 1'b0;
    r     = PH_W'((int'(p) + 1) % NUM_PHASES);
    for (int k = 1; k < NUM_PHASES; k++) begin
      c = (int'(p) + k) % NUM_PHASES;
      if (!found && !skip[c]) begin
        r     = PH_W'(c);
        found = 1'b1;
      end
    end
    if (!found && !skip[p]) r = p;
    return r;
  endfunction

  function automatic logic [PH_W-1:0] first_phase(input logic [NUM_PHASES-1:0] skip);
    logic [PH_W-1:0] r;
    logic            found;
    found = 1'b0;
    r     = '0;
    for (int k = 0; k < NUM_PHASES; k++) begin
      if (!found && !skip[k]) begin
        r     = PH_W'(k);
        found = 1'b1;
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rem_d   = rem_q;
    blink_d = blink_q;
    done_d  = 1'b0;
    nxt_ph  = (state_q == S_IDLE) ? first_phase(phase_skip_i)
                                  : next_phase(phase_q, phase_skip_i);
    if (!en_i) begin
      state_d = S_IDLE;
      phase_d = '0;
      rem_d   = '0;
      blink_d = 1'b0;
    end else if (flash_i) begin
      if (state_q != S_FLASH) begin
        state_d = S_FLASH;
        rem_d   = '0;
        blink_d = 1'b0;
      end else if (tick_i) begin
        blink_d = ~blink_q;
      end
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_GREEN;
          phase_d = nxt_ph;
          rem_d   = load(green_time_i[int'(nxt_ph)*CNT_WIDTH +: CNT_WIDTH]);
        end
        S_GREEN: if (tick_i) begin
          if (rem_q != '0) rem_d = rem_q - 1'b1;
          else begin
            state_d = S_YELLOW;
            rem_d   = load(yellow_time_i);
          end
        end
        S_YELLOW: if (tick_i) begin
          if (rem_q != '0) rem_d = rem_q - 1'b1;
          else begin
            state_d = S_ALLRED;
            rem_d   = CNT_WIDTH'(ALL_RED_TIME - 1);
          end
        end
        S_ALLRED: if (tick_i) begin
          if (rem_q != '0) rem_d = rem_q - 1'b1;
          else begin
            state_d = S_GREEN;
            phase_d = nxt_ph;
            done_d  = 1'b1;
            rem_d   = load(green_time_i[int'(nxt_ph)*CNT_WIDTH +: CNT_WIDTH]);
          end
        end
        S_FLASH: begin
          // Leaving flash always clears through ALL_RED. The phase held during flash
          // then advances as usual.
          state_d = S_ALLRED;
          rem_d   = CNT_WIDTH'(ALL_RED_TIME - 1);
          blink_d = 1'b0;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_PHASES; g++) begin : g_lamp
    traffic_phase_lamp u_lamp (
      .idle_i  (state_d == S_IDLE),
      .flash_i (state_d == S_FLASH),
      .blink_i (blink_d),
      .green_i (state_d == S_GREEN  && phase_d == PH_W'(g)),
      .yellow_i(state_d == S_YELLOW && phase_d == PH_W'(g)),
      .lamp_o  (light_d[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      rem_q   <= '0;
      blink_q <= 1'b0;
      done_q  <= 1'b0;
      light_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      rem_q   <= rem_d;
      blink_q <= blink_d;
      done_q  <= done_d;
      light_q <= light_d;
    end
  end

  assign light_o        = light_q;
  assign active_phase_o = phase_q;
  assign remaining_o    = rem_q;
  assign phase_done_o   = done_q;
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed-vector bench for traffic_phase_ctrl (4 phases, 8-bit counts, 2-tick all-red).
module tb_traffic_phase_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        en = 1'b0, tick = 1'b0, flash = 1'b0;
  logic [31:0] green;
  logic [7:0]  yellow;
  logic [3:0]  skip;
  logic [11:0] light;
  logic [1:0]  aph;
  logic [7:0]  rem;
  logic        done;

  int nvec = 0, nmis = 0;

  traffic_phase_ctrl #(.NUM_PHASES(4), .CNT_WIDTH(8), .ALL_RED_TIME(2)) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en), .tick_i(tick), .green_time_i(green),
    .yellow_time_i(yellow), .phase_skip_i(skip), .flash_i(flash),
    .light_o(light), .active_phase_o(aph), .remaining_o(rem), .phase_done_o(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic en, fl, tk;
    logic [11:0] light;
    logic [1:0]  ph;
    logic [7:0]  rem;
    logic        done;
  } vec_t;

  vec_t tbl[$];

  // Every phase red except p, which shows code c. Use p = -1 for all red.
  function automatic logic [11:0] lw(input int p, input logic [2:0] c);
    logic [11:0] r;
    r = {4{3'b100}};
    if (p >= 0) r[p*3 +: 3] = c;
    return r;
  endfunction

  function automatic logic [11:0] flw(input logic b);
    return {4{1'b0, b, 1'b0}};
  endfunction

  function automatic vec_t v(input logic e, input logic f, input logic t, input logic [11:0] l,
                             input logic [1:0] p, input logic [7:0] r, input logic d);
    vec_t x;
    x.en = e; x.fl = f; x.tk = t; x.light = l; x.ph = p; x.rem = r; x.done = d;
    return x;
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nmis++;
      $display("FAIL %s: got %0h want %0h", nm, act, req);
    end
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (done) begin ok = 1'b1; return; end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] AR, G0, Y0, G1, Y1, FL;
    bit ok;
    int exp_ph[$];
    int viol, ndone, nt;
    logic prev_done;
    int ng, nn;

    AR = lw(-1, 3'b000); G0 = lw(0, 3'b001); Y0 = lw(0, 3'b010);
    G1 = lw(1, 3'b001);  Y1 = lw(1, 3'b010); FL = flw(1'b1);

    green  = {8'd4, 8'd4, 8'd3, 8'd5};
    yellow = 8'd2;
    skip   = 4'b1100;
    #12 rst_n = 1'b1;
    chk("reset light", 32'(light), 0);
    chk("reset phase", 32'(aph), 0);
    chk("reset remaining", 32'(rem), 0);
    chk("reset phase_done", 32'(done), 0);

    // One record per clock: inputs before the edge, outputs just after it.
    tbl.push_back(v(1,0,0, G0,0,4,0));  // 0 IDLE exit, green 5 -> remaining 4
    tbl.push_back(v(1,0,1, G0,0,3,0));
    tbl.push_back(v(1,0,1, G0,0,2,0));
    tbl.push_back(v(1,0,1, G0,0,1,0));
    tbl.push_back(v(1,0,0, G0,0,1,0));  // no tick, hold
    tbl.push_back(v(1,0,1, G0,0,0,0));
    tbl.push_back(v(1,0,1, Y0,0,1,0));  // 6 expiry into yellow on a tick
    tbl.push_back(v(1,0,1, Y0,0,0,0));
    tbl.push_back(v(1,0,1, AR,0,1,0));
    tbl.push_back(v(1,0,1, AR,0,0,0));
    tbl.push_back(v(1,0,1, G1,1,2,1));  // 10 phase_done, phase 1 green 3
    tbl.push_back(v(1,0,0, G1,1,2,0));
    tbl.push_back(v(1,0,1, G1,1,1,0));
    tbl.push_back(v(1,0,1, G1,1,0,0));
    tbl.push_back(v(1,0,1, Y1,1,1,0));
    tbl.push_back(v(1,0,1, Y1,1,0,0));
    tbl.push_back(v(1,0,1, AR,1,1,0));
    tbl.push_back(v(1,0,1, AR,1,0,0));
    tbl.push_back(v(1,0,1, G0,0,4,1));  // 18 wrap to phase 0 (2,3 skipped)
    tbl.push_back(v(1,0,1, G0,0,3,0));
    tbl.push_back(v(1,0,1, G0,0,2,0));
    tbl.push_back(v(1,0,1, G0,0,1,0));
    tbl.push_back(v(1,0,1, G0,0,0,0));
    tbl.push_back(v(1,0,1, Y0,0,1,0));
    tbl.push_back(v(0,0,1, 12'h000,0,0,0)); // 24 en low mid-yellow
    tbl.push_back(v(1,0,0, G0,0,4,0));
    tbl.push_back(v(1,0,1, G0,0,3,0));
    tbl.push_back(v(1,0,1, G0,0,2,0));
    tbl.push_back(v(1,0,1, G0,0,1,0));
    tbl.push_back(v(1,0,1, G0,0,0,0));
    tbl.push_back(v(1,0,1, Y0,0,1,0));
    tbl.push_back(v(1,0,1, Y0,0,0,0));
    tbl.push_back(v(1,0,1, AR,0,1,0));
    tbl.push_back(v(1,0,1, AR,0,0,0));
    tbl.push_back(v(1,0,1, G1,1,2,1));
    tbl.push_back(v(1,1,0, 12'h000,1,0,0)); // 35 flash entry mid-green ph1
    tbl.push_back(v(1,1,1, FL,1,0,0));
    tbl.push_back(v(1,1,0, FL,1,0,0));
    tbl.push_back(v(1,1,1, 12'h000,1,0,0));
    tbl.push_back(v(1,1,1, FL,1,0,0));
    tbl.push_back(v(1,0,0, AR,1,1,0));  // 40 flash exit
    tbl.push_back(v(1,0,1, AR,1,0,0));
    tbl.push_back(v(1,0,1, G0,0,4,1));
    tbl.push_back(v(0,1,1, 12'h000,0,0,0)); // 43 en beats flash
    tbl.push_back(v(1,0,0, G0,0,4,0));

    foreach (tbl[i]) begin
      en = tbl[i].en; flash = tbl[i].fl; tick = tbl[i].tk;
      cyc();
      nvec++;
      if (light !== tbl[i].light || aph !== tbl[i].ph || rem !== tbl[i].rem ||
          done !== tbl[i].done) begin
        nmis++;
        $display("FAIL vec %0d: got light=%h ph=%0d rem=%0d done=%b want light=%h ph=%0d rem=%0d done=%b",
                 i, light, aph, rem, done, tbl[i].light, tbl[i].ph, tbl[i].rem, tbl[i].done);
      end
    end
    tick = 1'b0; flash = 1'b0;

    // Zero green duration lasts exactly one tick.
    en = 1'b0; cyc();
    green[7:0] = 8'd0; en = 1'b1; cyc();
    chk("zero-dur green light", 32'(light), 32'(G0));
    chk("zero-dur remaining", 32'(rem), 0);
    tick = 1'b1; cyc(); tick = 1'b0;
    chk("zero-dur one tick then yellow", 32'(light), 32'(Y0));
    cyc(); cyc(); cyc();
    chk("no tick holds remaining", 32'(rem), 1);

    // Skip mask: served order 0,3,0,3, then phase 0 only, then all skipped advances.
    en = 1'b0; cyc();
    skip = 4'b0110; green = {8'd1, 8'd1, 8'd1, 8'd1}; yellow = 8'd1; en = 1'b1; cyc();
    chk("skip first phase", 32'(aph), 0);
    tick = 1'b1;
    exp_ph = '{3, 0, 3};
    foreach (exp_ph[i]) begin
      wait_done(ok);
      chk("skip 0110 done seen", 32'(ok), 1);
      chk("skip 0110 served", 32'(aph), 32'(exp_ph[i]));
    end
    skip = 4'b1110;
    exp_ph = '{0, 0, 0};
    foreach (exp_ph[i]) begin
      wait_done(ok);
      chk("skip 1110 done seen", 32'(ok), 1);
      chk("skip 1110 served", 32'(aph), 32'(exp_ph[i]));
    end
    skip = 4'b1111;
    exp_ph = '{1, 2};
    foreach (exp_ph[i]) begin
      wait_done(ok);
      chk("skip all done seen", 32'(ok), 1);
      chk("skip all served", 32'(aph), 32'(exp_ph[i]));
    end

    // Asynchronous reset in the middle of ALL_RED.
    skip = 4'b0000; ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      cyc();
      if (light === AR) ok = 1'b1;
    end
    chk("reached all-red", 32'(ok), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset light", 32'(light), 0);
    chk("async reset remaining", 32'(rem), 0);
    chk("async reset phase", 32'(aph), 0);
    #1 rst_n = 1'b1;

    // Random run: no conflicting lamps outside flash, and phase_done never held high.
    viol = 0; ndone = 0; nt = 0; prev_done = 1'b0;
    en = 1'b1; flash = 1'b0;
    for (int c = 0; c < 40000 && nt < 10000; c++) begin
      if (c % 37 == 0) begin
        for (int p = 0; p < 4; p++) green[p*8 +: 8] = 8'($urandom_range(3, 0));
        yellow = 8'($urandom_range(2, 0));
        skip   = 4'($urandom);
      end
      en   = ($urandom_range(99, 0) != 0);
      tick = $urandom_range(1, 0) == 1;
      if (tick) nt++;
      cyc();
      ng = 0; nn = 0;
      for (int p = 0; p < 4; p++) begin
        if (light[p*3])     ng++;
        if (light[p*3 +: 2] != 2'b00) nn++;
        if (light[p*3 +: 3] != 3'b000 && light[p*3 +: 3] != 3'b001 &&
            light[p*3 +: 3] != 3'b010 && light[p*3 +: 3] != 3'b100) viol++;
      end
      if (ng > 1 || nn > 1) viol++;
      if (done && prev_done) viol++;
      if (done) ndone++;
      prev_done = done;
    end
    tick = 1'b0;
    chk("random ticks completed", 32'(nt), 10000);
    chk("random invariant violations", 32'(viol), 0);
    chk("random phase_done seen", 32'(ndone > 0), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
